race_frame_sequencer: RTL and testbench

//  Per-frame game-state controller feeding track_view/racer_view with positions that stay stable for a whole frame.
//  On each vblank start: requests a physics step for player then opponent, then a collision check.

---
 rtl/race_pkg.sv | 22 ++
 rtl/seq_req_port.sv | 38 +++
 rtl/race_frame_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_race_frame_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/race_pkg.sv
// Shared types and defaults for the per-frame race sequencer.
package race_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_P,
        REQ_O,
        COLL,
        COMMIT,
        ABORT
    } seq_state_t;

    typedef enum logic {
        RACER_PLAYER   = 1'b0,
        RACER_OPPONENT = 1'b1
    } racer_id_t;

    localparam int DIR_MOD       = 360;
    localparam int DEF_V_ACTIVE  = 768;
    localparam int DEF_TRACK_MAX = 511;

endpackage

// File: rtl/seq_req_port.sv
// Generic request/acknowledge driver: start raises req next cycle, req holds until ack.
module seq_req_port (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic start_in,
    input  logic clear_in,
    input  logic ack_in,
    output logic req_out,
    output logic done_out
);

    logic req_q;
    logic req_d;

    // Clear wins over start so an abort can never leave a request dangling.
    always_comb begin
        req_d = req_q;
        if (clear_in) begin
            req_d = 1'b0;
        end else if (start_in) begin
            req_d = 1'b1;
        end else if (req_q && ack_in) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            req_q <= 1'b0;
        end else begin
            req_q <= req_d;
        end
    end

    assign req_out  = req_q;
    assign done_out = req_q & ack_in & ~clear_in;

endmodule

// File: rtl/race_frame_sequencer.sv
// Per-frame game-state sequencer: physics for player/opponent, collision, then one-cycle commit.
// Optional SEQ_OVERRUN_CNT_EN adds a saturating abort counter port.
module race_frame_sequencer
    import race_pkg::*;
#(
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int POS_W     = 11,
    parameter int DIR_W     = 9,
    parameter int TRACK_MAX = DEF_TRACK_MAX,
    parameter int INIT_PX   = 191,
    parameter int INIT_PY   = 191,
    parameter int INIT_OX   = 319,
    parameter int INIT_OY   = 319,
    parameter int INIT_DIR  = 270
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [9:0]       vcount_in,
    input  logic             enable_in,
    output logic             step_req_out,
    output logic             step_id_out,
    input  logic             step_ack_in,
    input  logic [POS_W-1:0] step_x_in,
    input  logic [POS_W-1:0] step_y_in,
    input  logic [DIR_W-1:0] step_dir_in,
    output logic             coll_req_out,
    input  logic             coll_ack_in,
    input  logic             coll_hit_in,
    output logic [POS_W-1:0] player_x_out,
    output logic [POS_W-1:0] player_y_out,
    output logic [DIR_W-1:0] direction_out,
    output logic [POS_W-1:0] opponent_x_out,
    output logic [POS_W-1:0] opponent_y_out,
    output logic             collision_out,
    output logic             frame_tick_out,
    output logic             overrun_out
`ifdef SEQ_OVERRUN_CNT_EN
    ,
    output logic [7:0]       overrun_cnt_out
`endif
);

    localparam logic [9:0]       VBLANK_LINE = 10'(V_ACTIVE);
    localparam logic [POS_W-1:0] POS_MAX     = POS_W'(TRACK_MAX);
    localparam logic [DIR_W-1:0] DIR_WRAP    = DIR_W'(DIR_MOD);
    localparam logic [POS_W-1:0] RST_PX      = POS_W'(INIT_PX);
    localparam logic [POS_W-1:0] RST_PY      = POS_W'(INIT_PY);
    localparam logic [POS_W-1:0] RST_OX      = POS_W'(INIT_OX);
    localparam logic [POS_W-1:0] RST_OY      = POS_W'(INIT_OY);
    localparam logic [DIR_W-1:0] RST_DIR     = DIR_W'(INIT_DIR);

    function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] v);
        return (v > POS_MAX) ? POS_MAX : v;
    endfunction

    function automatic logic [DIR_W-1:0] wrap_dir(input logic [DIR_W-1:0] d);
        return (d >= DIR_WRAP) ? d - DIR_WRAP : d;
    endfunction

    seq_state_t       state_q, state_d;
    racer_id_t        step_id_q, step_id_d;
    logic [9:0]       vcount_prev_q, vcount_prev_d;
    logic             step_start_q, step_start_d;
    logic             coll_start_q, coll_start_d;
    logic [POS_W-1:0] stg_px_q, stg_px_d, stg_py_q, stg_py_d;
    logic [POS_W-1:0] stg_ox_q, stg_ox_d, stg_oy_q, stg_oy_d;
    logic [DIR_W-1:0] stg_dir_q, stg_dir_d;
    logic             stg_hit_q, stg_hit_d;
    logic [POS_W-1:0] px_q, px_d, py_q, py_d, ox_q, ox_d, oy_q, oy_d;
    logic [DIR_W-1:0] dir_q, dir_d;
    logic             hit_q, hit_d;
    logic             tick_q, tick_d;
    logic             overrun_q, overrun_d;

    logic             vblank_start;
    logic             abort_now;
    logic             step_done;
    logic             coll_done;

    assign vblank_start = (vcount_in == VBLANK_LINE) && (vcount_prev_q != VBLANK_LINE);
    assign abort_now    = ((state_q == REQ_P) || (state_q == REQ_O) || (state_q == COLL))
                          && (vcount_in == 10'd0);

    seq_req_port u_step_port (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .start_in (step_start_q),
        .clear_in (abort_now),
        .ack_in   (step_ack_in),
        .req_out  (step_req_out),
        .done_out (step_done)
    );

    seq_req_port u_coll_port (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .start_in (coll_start_q),
        .clear_in (abort_now),
        .ack_in   (coll_ack_in),
        .req_out  (coll_req_out),
        .done_out (coll_done)
    );

    always_comb begin
        state_d       = state_q;
        step_id_d     = step_id_q;
        vcount_prev_d = vcount_in;
        step_start_d  = 1'b0;
        coll_start_d  = 1'b0;
        tick_d        = 1'b0;
        overrun_d     = 1'b0;
        stg_px_d      = stg_px_q;
        stg_py_d      = stg_py_q;
        stg_dir_d     = stg_dir_q;
        stg_ox_d      = stg_ox_q;
        stg_oy_d      = stg_oy_q;
        stg_hit_d     = stg_hit_q;
        px_d          = px_q;
        py_d          = py_q;
        dir_d         = dir_q;
        ox_d          = ox_q;
        oy_d          = oy_q;
        hit_d         = hit_q;

        // The deadline is checked before any ack so a late result is never committed.
        if (abort_now) begin
            state_d   = ABORT;
            overrun_d = 1'b1;
            stg_px_d  = px_q;
            stg_py_d  = py_q;
            stg_dir_d = dir_q;
            stg_ox_d  = ox_q;
            stg_oy_d  = oy_q;
            stg_hit_d = hit_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (vblank_start && enable_in) begin
                        state_d      = REQ_P;
                        step_start_d = 1'b1;
                        step_id_d    = RACER_PLAYER;
                    end
                end
                REQ_P: begin
                    if (step_done) begin
                        stg_px_d     = clamp_pos(step_x_in);
                        stg_py_d     = clamp_pos(step_y_in);
                        stg_dir_d    = wrap_dir(step_dir_in);
                        state_d      = REQ_O;
                        step_start_d = 1'b1;
                        step_id_d    = RACER_OPPONENT;
                    end
                end
                REQ_O: begin
                    if (step_done) begin
                        stg_ox_d     = clamp_pos(step_x_in);
                        stg_oy_d     = clamp_pos(step_y_in);
                        state_d      = COLL;
                        coll_start_d = 1'b1;
                    end
                end
                COLL: begin
                    // Outputs load on entry to COMMIT so they change in the same cycle as the tick.
                    if (coll_done) begin
                        stg_hit_d = coll_hit_in;
                        state_d   = COMMIT;
                        tick_d    = 1'b1;
                        px_d      = stg_px_q;
                        py_d      = stg_py_q;
                        dir_d     = stg_dir_q;
                        ox_d      = stg_ox_q;
                        oy_d      = stg_oy_q;
                        hit_d     = coll_hit_in;
                    end
                end
                COMMIT:  state_d = IDLE;
                ABORT:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= IDLE;
            step_id_q     <= RACER_PLAYER;
            vcount_prev_q <= 10'd0;
            step_start_q  <= 1'b0;
            coll_start_q  <= 1'b0;
            tick_q        <= 1'b0;
            overrun_q     <= 1'b0;
            stg_px_q      <= RST_PX;
            stg_py_q      <= RST_PY;
            stg_dir_q     <= RST_DIR;
            stg_ox_q      <= RST_OX;
            stg_oy_q      <= RST_OY;
            stg_hit_q     <= 1'b0;
            px_q          <= RST_PX;
            py_q          <= RST_PY;
            dir_q         <= RST_DIR;
            ox_q          <= RST_OX;
            oy_q          <= RST_OY;
            hit_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_id_q     <= step_id_d;
            vcount_prev_q <= vcount_prev_d;
            step_start_q  <= step_start_d;
            coll_start_q  <= coll_start_d;
            tick_q        <= tick_d;
            overrun_q     <= overrun_d;
            stg_px_q      <= stg_px_d;
            stg_py_q      <= stg_py_d;
            stg_dir_q     <= stg_dir_d;
            stg_ox_q      <= stg_ox_d;
            stg_oy_q      <= stg_oy_d;
            stg_hit_q     <= stg_hit_d;
            px_q          <= px_d;
            py_q          <= py_d;
            dir_q         <= dir_d;
            ox_q          <= ox_d;
            oy_q          <= oy_d;
            hit_q         <= hit_d;
        end
    end

`ifdef SEQ_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt_q;
    logic [7:0] overrun_cnt_d;

    always_comb begin
        overrun_cnt_d = overrun_cnt_q;
        if (abort_now && (overrun_cnt_q != 8'hFF)) begin
            overrun_cnt_d = overrun_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            overrun_cnt_q <= 8'd0;
        end else begin
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign overrun_cnt_out = overrun_cnt_q;
`endif

    assign step_id_out    = step_id_q;
    assign player_x_out   = px_q;
    assign player_y_out   = py_q;
    assign direction_out  = dir_q;
    assign opponent_x_out = ox_q;
    assign opponent_y_out = oy_q;
    assign collision_out  = hit_q;
    assign frame_tick_out = tick_q;
    assign overrun_out    = overrun_q;

endmodule

// File: tb/tb_race_frame_sequencer.sv
// Directed bench for race_frame_sequencer (SEQ_OVERRUN_CNT_EN adds counter checks).
module tb_race_frame_sequencer;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [9:0]  vcount_in;
    logic        enable_in;
    logic        step_req_out;
    logic        step_id_out;
    logic        step_ack_in;
    logic [10:0] step_x_in;
    logic [10:0] step_y_in;
    logic [8:0]  step_dir_in;
    logic        coll_req_out;
    logic        coll_ack_in;
    logic        coll_hit_in;
    logic [10:0] player_x_out;
    logic [10:0] player_y_out;
    logic [8:0]  direction_out;
    logic [10:0] opponent_x_out;
    logic [10:0] opponent_y_out;
    logic        collision_out;
    logic        frame_tick_out;
    logic        overrun_out;
`ifdef SEQ_OVERRUN_CNT_EN
    logic [7:0]  overrun_cnt_out;
`endif

    int checks   = 0;
    int failures = 0;

    race_frame_sequencer dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .vcount_in      (vcount_in),
        .enable_in      (enable_in),
        .step_req_out   (step_req_out),
        .step_id_out    (step_id_out),
        .step_ack_in    (step_ack_in),
        .step_x_in      (step_x_in),
        .step_y_in      (step_y_in),
        .step_dir_in    (step_dir_in),
        .coll_req_out   (coll_req_out),
        .coll_ack_in    (coll_ack_in),
        .coll_hit_in    (coll_hit_in),
        .player_x_out   (player_x_out),
        .player_y_out   (player_y_out),
        .direction_out  (direction_out),
        .opponent_x_out (opponent_x_out),
        .opponent_y_out (opponent_y_out),
        .collision_out  (collision_out),
        .frame_tick_out (frame_tick_out),
        .overrun_out    (overrun_out)
`ifdef SEQ_OVERRUN_CNT_EN
        ,
        .overrun_cnt_out(overrun_cnt_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic chk_outputs(input string tag, input int px, input int py, input int dir,
                               input int ox, input int oy, input int hit);
        chk({tag, "_px"},  32'(player_x_out),   32'(px));
        chk({tag, "_py"},  32'(player_y_out),   32'(py));
        chk({tag, "_dir"}, 32'(direction_out),  32'(dir));
        chk({tag, "_ox"},  32'(opponent_x_out), 32'(ox));
        chk({tag, "_oy"},  32'(opponent_y_out), 32'(oy));
        chk({tag, "_hit"}, 32'(collision_out),  32'(hit));
    endtask

    // Runs one frame with acks held high; returns the tick cycle counted from the vblank cycle.
    task automatic run_frame(input int px, input int py, input int pd, input int ox, input int oy,
                             input logic hit, output int lat);
        vcount_in = 10'd770;
        tick();
        vcount_in   = 10'd768;
        step_x_in   = 11'(px);
        step_y_in   = 11'(py);
        step_dir_in = 9'(pd);
        coll_hit_in = hit;
        step_ack_in = 1'b1;
        coll_ack_in = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            tick();
            if (k == 3) begin
                step_x_in   = 11'(ox);
                step_y_in   = 11'(oy);
                step_dir_in = 9'd511;
            end
            if (frame_tick_out) lat = k;
        end
    endtask

    initial begin
        int lat;
        logic saw_req;
        logic saw_tick;

        rst_n_in    = 1'b0;
        vcount_in   = 10'd100;
        enable_in   = 1'b1;
        step_ack_in = 1'b0;
        coll_ack_in = 1'b0;
        coll_hit_in = 1'b0;
        step_x_in   = '0;
        step_y_in   = '0;
        step_dir_in = '0;

        // Reset state
        #12;
        chk_outputs("rst", 191, 191, 270, 319, 319, 0);
        chk("rst_tick", 32'(frame_tick_out), 0);
        chk("rst_ovr",  32'(overrun_out), 0);
        chk("rst_sreq", 32'(step_req_out), 0);
        chk("rst_creq", 32'(coll_req_out), 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (4) tick();
        chk_outputs("idle", 191, 191, 270, 319, 319, 0);
        chk("idle_tick", 32'(frame_tick_out), 0);

        // Normal frame, same-cycle acks
        run_frame(200, 210, 90, 300, 305, 1'b0, lat);
        chk("f1_lat", 32'(lat), 32'd7);
        chk_outputs("f1", 200, 210, 90, 300, 305, 0);
        tick();
        chk("f1_tick_off", 32'(frame_tick_out), 0);

        // Clamp and heading wrap
        run_frame(600, 100, 400, 700, 330, 1'b1, lat);
        chk("f2_lat", 32'(lat), 32'd7);
        chk_outputs("f2", 511, 100, 40, 511, 330, 1);

        // Withheld collision ack runs into the deadline; ack on the deadline cycle is ignored
        vcount_in = 10'd770;
        tick();
        vcount_in   = 10'd768;
        step_x_in   = 11'd250;
        step_y_in   = 11'd260;
        step_dir_in = 9'd100;
        step_ack_in = 1'b1;
        coll_ack_in = 1'b0;
        saw_tick = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 3) begin
                step_x_in = 11'd270;
                step_y_in = 11'd280;
            end
            if (frame_tick_out) saw_tick = 1'b1;
        end
        chk("ab_creq_held", 32'(coll_req_out), 1);
        chk("ab_no_tick", 32'(saw_tick), 0);
        vcount_in   = 10'd0;
        coll_ack_in = 1'b1;
        tick();
        chk("ab_ovr", 32'(overrun_out), 1);
        chk("ab_tick", 32'(frame_tick_out), 0);
        chk("ab_creq", 32'(coll_req_out), 0);
        chk_outputs("ab", 511, 100, 40, 511, 330, 1);
`ifdef SEQ_OVERRUN_CNT_EN
        chk("ab_cnt", 32'(overrun_cnt_out), 1);
`endif
        tick();
        chk("ab_ovr_pulse", 32'(overrun_out), 0);
        chk("ab_tick2", 32'(frame_tick_out), 0);

        // Disabled vblank with spurious acks, then enable without a new vblank edge
        enable_in   = 1'b0;
        step_ack_in = 1'b1;
        coll_ack_in = 1'b1;
        vcount_in   = 10'd768;
        saw_req  = 1'b0;
        saw_tick = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (step_req_out || coll_req_out) saw_req = 1'b1;
            if (frame_tick_out) saw_tick = 1'b1;
            if (k == 4) enable_in = 1'b1;
        end
        chk("dis_no_req", 32'(saw_req), 0);
        chk("dis_no_tick", 32'(saw_tick), 0);
        chk_outputs("dis", 511, 100, 40, 511, 330, 1);

        // Reset in REQ_O with request pending
        vcount_in = 10'd770;
        tick();
        vcount_in   = 10'd768;
        step_x_in   = 11'd50;
        step_y_in   = 11'd60;
        step_dir_in = 9'd10;
        step_ack_in = 1'b1;
        coll_ack_in = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 3) step_ack_in = 1'b0;
        end
        chk("r6_sreq", 32'(step_req_out), 1);
        chk("r6_sid", 32'(step_id_out), 1);
        rst_n_in = 1'b0;
        #1;
        chk("r6_sreq_rst", 32'(step_req_out), 0);
        chk("r6_creq_rst", 32'(coll_req_out), 0);
        chk_outputs("r6", 191, 191, 270, 319, 319, 0);
        vcount_in = 10'd100;
        tick();
        rst_n_in = 1'b1;
        saw_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (step_req_out || coll_req_out) saw_req = 1'b1;
        end
        chk("r6_idle_req", 32'(saw_req), 0);
        chk("r6_idle_tick", 32'(frame_tick_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
